// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, im addressing, IF/ID register and fetch counter.
// Optional IF_FETCH_FAULT_EN adds a sticky fault on misaligned or out-of-range redirect targets.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IM_AW     = 6,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_data,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [25:0]      jump_target,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic [31:0]      fetch_count,
  output logic             fetch_fault
);

  function automatic logic [31:0] align_target(input logic [31:0] t);
    return {t[31:2], 2'b00};
  endfunction

  function automatic logic bad_target(input logic [31:0] t);
    return (t[1:0] != 2'b00) || ((t >> (IM_AW + 2)) != 32'd0);
  endfunction

  logic [31:0] pc_p0;
  logic [31:0] pc4_p0;
  logic        redirect;
  logic [31:0] target_raw;
  logic        fault_q;

  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] pc4_nxt;
  logic        vld_nxt;
  logic [31:0] cnt_nxt;
  logic        fault_nxt;

  assign pc      = pc_p0;
  assign pc4_p0  = pc_p0 + 32'd4;
  assign im_addr = pc_p0[IM_AW+1:2];

  assign redirect   = jump | branch_taken;
  assign target_raw = jump ? {if_id_pc4[31:28], jump_target, 2'b00} : branch_target;

  always_comb begin
    pc_nxt    = pc_p0;
    instr_nxt = if_id_instr;
    pc4_nxt   = if_id_pc4;
    vld_nxt   = if_id_valid;
    cnt_nxt   = fetch_count;
    fault_nxt = fault_q;
`ifdef IF_FETCH_FAULT_EN
    if (fault_q) begin
      vld_nxt = 1'b0;
    end else if (redirect) begin
      instr_nxt = NOP_INSTR;
      pc4_nxt   = 32'd0;
      vld_nxt   = 1'b0;
      // A bad target freezes the PC instead of fetching from it.
      if (bad_target(target_raw)) fault_nxt = 1'b1;
      else                        pc_nxt    = target_raw;
    end else
`else
    if (redirect) begin
      pc_nxt    = align_target(target_raw);
      instr_nxt = NOP_INSTR;
      pc4_nxt   = 32'd0;
      vld_nxt   = 1'b0;
    end else
`endif
    if (stall) begin
      if (flush) begin
        instr_nxt = NOP_INSTR;
        pc4_nxt   = 32'd0;
        vld_nxt   = 1'b0;
      end
    end else begin
      pc_nxt = pc4_p0;
      if (flush) begin
        instr_nxt = NOP_INSTR;
        pc4_nxt   = 32'd0;
        vld_nxt   = 1'b0;
      end else begin
        instr_nxt = im_data;
        pc4_nxt   = pc4_p0;
        vld_nxt   = 1'b1;
        cnt_nxt   = fetch_count + 32'd1;
      end
    end
  end

  // IF/ID boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0       <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      pc_p0       <= pc_nxt;
      if_id_instr <= instr_nxt;
      if_id_pc4   <= pc4_nxt;
      if_id_valid <= vld_nxt;
      fetch_count <= cnt_nxt;
    end
  end

`ifdef IF_FETCH_FAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_nxt;
  end
`else
  assign fault_q = 1'b0;
`endif

  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; im[k] = k+1, expectations hand-computed per scenario.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  im_addr;
  logic [31:0] im_data;
  logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [25:0] jump_target = 26'd0;
  logic [31:0] pc, if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid, fetch_fault;

  int assertions = 0;
  int failures   = 0;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_data(im_data),
    .stall(stall), .flush(flush), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;
  assign im_data = {26'd0, im_addr} + 32'd1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    assertions++; if (pc !== 32'd0) begin failures++; $display("FAIL reset_pc: got %h expected %h", pc, 32'd0); end
    assertions++; if (if_id_instr !== 32'd0) begin failures++; $display("FAIL reset_instr: got %h expected %h", if_id_instr, 32'd0); end
    assertions++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
    assertions++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
    assertions++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 4; k++) begin
      step();
      assertions++; if (if_id_instr !== 32'(k)) begin failures++; $display("FAIL seq_instr[%0d]: got %h expected %h", k, if_id_instr, 32'(k)); end
      assertions++; if (if_id_pc4 !== 32'(4*k)) begin failures++; $display("FAIL seq_pc4[%0d]: got %h expected %h", k, if_id_pc4, 32'(4*k)); end
      assertions++; if (if_id_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d]: got %b expected 1", k, if_id_valid); end
    end
    assertions++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL seq_count: got %0d expected 4", fetch_count); end
    assertions++; if (pc !== 32'd16) begin failures++; $display("FAIL seq_pc: got %h expected %h", pc, 32'd16); end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      assertions++; if (pc !== 32'd8) begin failures++; $display("FAIL stall_pc[%0d]: got %h expected 8", k, pc); end
      assertions++; if (if_id_instr !== 32'd2) begin failures++; $display("FAIL stall_instr[%0d]: got %h expected 2", k, if_id_instr); end
      assertions++; if (fetch_count !== 32'd2) begin failures++; $display("FAIL stall_count[%0d]: got %0d expected 2", k, fetch_count); end
    end
    stall = 0;
    step();
    assertions++; if (pc !== 32'd12) begin failures++; $display("FAIL stall_resume_pc: got %h expected c", pc); end
    assertions++; if (if_id_instr !== 32'd3) begin failures++; $display("FAIL stall_resume_instr: got %h expected 3", if_id_instr); end
    assertions++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL stall_resume_count: got %0d expected 3", fetch_count); end
    stall = 1; flush = 1;
    step();
    stall = 0; flush = 0;
    assertions++; if (pc !== 32'd12) begin failures++; $display("FAIL stall_flush_pc: got %h expected c", pc); end
    assertions++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL stall_flush_valid: got %b expected 0", if_id_valid); end
    assertions++; if (if_id_instr !== 32'd0) begin failures++; $display("FAIL stall_flush_instr: got %h expected 0", if_id_instr); end
    assertions++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL stall_flush_count: got %0d expected 3", fetch_count); end
  endtask

  task automatic test_branch();
    stall = 1; branch_taken = 1; branch_target = 32'h20;
    step();
    stall = 0; branch_taken = 0;
    assertions++; if (pc !== 32'h20) begin failures++; $display("FAIL br_pc: got %h expected 20", pc); end
    assertions++; if (im_addr !== 6'd8) begin failures++; $display("FAIL br_imaddr: got %0d expected 8", im_addr); end
    assertions++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL br_valid: got %b expected 0", if_id_valid); end
    assertions++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL br_count: got %0d expected 3", fetch_count); end
    step();
    assertions++; if (if_id_instr !== 32'd9) begin failures++; $display("FAIL br_next_instr: got %h expected 9", if_id_instr); end
    assertions++; if (if_id_pc4 !== 32'h24) begin failures++; $display("FAIL br_next_pc4: got %h expected 24", if_id_pc4); end
  endtask

  task automatic test_jump();
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
`ifdef IF_FETCH_FAULT_EN
    exp_pc  = 32'h0000_0014;
    exp_cnt = 32'd4;
`else
    branch_taken = 1; branch_target = 32'h1000_000C;
    step();
    branch_taken = 0;
    assertions++; if (im_addr !== 6'd3) begin failures++; $display("FAIL jmp_setup_imaddr: got %0d expected 3", im_addr); end
    step();
    assertions++; if (if_id_pc4 !== 32'h1000_0010) begin failures++; $display("FAIL jmp_setup_pc4: got %h expected 10000010", if_id_pc4); end
    exp_pc  = 32'h1000_0014;
    exp_cnt = 32'd5;
`endif
    jump = 1; jump_target = 26'h5; branch_taken = 1; branch_target = 32'h40;
    step();
    jump = 0; branch_taken = 0;
    assertions++; if (pc !== exp_pc) begin failures++; $display("FAIL jmp_pc: got %h expected %h", pc, exp_pc); end
    assertions++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL jmp_valid: got %b expected 0", if_id_valid); end
    assertions++; if (if_id_pc4 !== 32'd0) begin failures++; $display("FAIL jmp_pc4: got %h expected 0", if_id_pc4); end
    assertions++; if (fetch_count !== exp_cnt) begin failures++; $display("FAIL jmp_count: got %0d expected %0d", fetch_count, exp_cnt); end
  endtask

  task automatic test_flush();
    logic [31:0] p0;
    logic [31:0] c0;
`ifdef IF_FETCH_FAULT_EN
    p0 = 32'h14; c0 = 32'd4;
`else
    p0 = 32'h1000_0014; c0 = 32'd5;
`endif
    flush = 1;
    step();
    flush = 0;
    assertions++; if (pc !== p0 + 32'd4) begin failures++; $display("FAIL flush_pc: got %h expected %h", pc, p0 + 32'd4); end
    assertions++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", if_id_valid); end
    assertions++; if (fetch_count !== c0) begin failures++; $display("FAIL flush_count: got %0d expected %0d", fetch_count, c0); end
    step();
    assertions++; if (if_id_instr !== 32'd7) begin failures++; $display("FAIL flush_next_instr: got %h expected 7", if_id_instr); end
    assertions++; if (if_id_pc4 !== p0 + 32'd8) begin failures++; $display("FAIL flush_next_pc4: got %h expected %h", if_id_pc4, p0 + 32'd8); end
    assertions++; if (fetch_count !== c0 + 32'd1) begin failures++; $display("FAIL flush_next_count: got %0d expected %0d", fetch_count, c0 + 32'd1); end
    // Asynchronous reset, sampled away from any clock edge.
    @(negedge clk);
    rst_n = 0;
    #1;
    assertions++; if (pc !== 32'd0) begin failures++; $display("FAIL async_rst_pc: got %h expected 0", pc); end
    assertions++; if (if_id_instr !== 32'd0) begin failures++; $display("FAIL async_rst_instr: got %h expected 0", if_id_instr); end
    assertions++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid: got %b expected 0", if_id_valid); end
    assertions++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL async_rst_count: got %0d expected 0", fetch_count); end
    step();
    rst_n = 1;
  endtask

  task automatic test_fault();
    do_reset();
    branch_taken = 1; branch_target = 32'h22;
    step();
    branch_taken = 0;
`ifdef IF_FETCH_FAULT_EN
    assertions++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL fault_set: got %b expected 1", fetch_fault); end
    assertions++; if (pc !== 32'd0) begin failures++; $display("FAIL fault_pc: got %h expected 0", pc); end
    step();
    assertions++; if (pc !== 32'd0) begin failures++; $display("FAIL fault_hold_pc: got %h expected 0", pc); end
    assertions++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL fault_hold_valid: got %b expected 0", if_id_valid); end
    assertions++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL fault_sticky: got %b expected 1", fetch_fault); end
`else
    assertions++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL nofault_flag: got %b expected 0", fetch_fault); end
    assertions++; if (pc !== 32'h20) begin failures++; $display("FAIL nofault_pc: got %h expected 20", pc); end
    step();
    assertions++; if (if_id_instr !== 32'd9) begin failures++; $display("FAIL nofault_instr: got %h expected 9", if_id_instr); end
    assertions++; if (fetch_count !== 32'd1) begin failures++; $display("FAIL nofault_count: got %0d expected 1", fetch_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump();
    test_flush();
    test_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
